third_task_ctrl: RTL and testbench

//  Operand sequencer for the third_task three-operand datapath (3 x 8-bit in, 17-bit out).

---
 rtl/third_task_ctrl_pkg.sv | 18 +
 rtl/third_task.sv | 26 ++
 rtl/third_task_ctrl.sv | 169 ++++++++++++++++
 tb/tb_third_task_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/third_task_ctrl_pkg.sv
// Shared types and constants for the third_task operand sequencer.
// State encodings and counter widths are fixed here so the bench and RTL agree.
package third_task_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   localparam int IDX_W    = 2;
   localparam int SETTLE_W = 4;

   localparam logic [IDX_W-1:0] IDX_FIRST = 2'd0;
   localparam logic [IDX_W-1:0] IDX_MID   = 2'd1;
   localparam logic [IDX_W-1:0] IDX_LAST  = 2'd2;

endpackage

// File: rtl/third_task.sv
// Combinational three-operand datapath: result = m1 * m2 + m3.
// Operands are zero-extended to the result width before the arithmetic.
module third_task #(
   parameter int W_IN  = 8,
   parameter int W_OUT = 17
) (
   input  logic [W_IN-1:0]  i_m1,
   input  logic [W_IN-1:0]  i_m2,
   input  logic [W_IN-1:0]  i_m3,
   output logic [W_OUT-1:0] o_res
);

   logic [W_OUT-1:0] w_m1;
   logic [W_OUT-1:0] w_m2;
   logic [W_OUT-1:0] w_m3;

   assign w_m1 = {{(W_OUT-W_IN){1'b0}}, i_m1};
   assign w_m2 = {{(W_OUT-W_IN){1'b0}}, i_m2};
   assign w_m3 = {{(W_OUT-W_IN){1'b0}}, i_m3};

   // W_OUT >= 2*W_IN + 1 keeps the product-plus-addend free of overflow
   always_comb begin
      o_res = (w_m1 * w_m2) + w_m3;
   end

endmodule

// File: rtl/third_task_ctrl.sv
// Operand sequencer: gathers three bytes, holds them on the third_task datapath for
// SETTLE_CYC cycles, then registers the result and offers it on a valid/ready port.
module third_task_ctrl
   import third_task_ctrl_pkg::*;
#(
   parameter int W_IN       = 8,
   parameter int W_OUT      = 17,
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  in_data,
   input  logic             flush,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [W_OUT-1:0] res_data,
   output logic [CNT_W-1:0] done_cnt,
   output logic             busy
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_idx;
   logic [SETTLE_W-1:0] r_settle;
   logic [W_IN-1:0]     r_op [3];
   logic                r_res_valid;
   logic [W_OUT-1:0]    r_res_data;
   logic [CNT_W-1:0]    r_done_cnt;
   logic [W_OUT-1:0]    w_dp_res;
   logic                w_accept;

   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

   assign w_accept  = in_valid & in_ready;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign done_cnt  = r_done_cnt;

   third_task #(
      .W_IN  (W_IN),
      .W_OUT (W_OUT)
   ) u_datapath (
      .i_m1  (r_op[0]),
      .i_m2  (r_op[1]),
      .i_m3  (r_op[2]),
      .o_res (w_dp_res)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; flush overrides every transition
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = ST_COLLECT;
      end else begin
         case (r_state)
            ST_COLLECT: begin
               if (w_accept && (r_idx == IDX_LAST)) begin
                  w_state_nxt = ST_SETTLE;
               end else begin
                  w_state_nxt = ST_COLLECT;
               end
            end
            ST_SETTLE: begin
               if (r_settle == {SETTLE_W{1'b0}}) begin
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_state_nxt = ST_SETTLE;
               end
            end
            ST_HOLD: begin
               if (res_ready) begin
                  w_state_nxt = ST_COLLECT;
               end else begin
                  w_state_nxt = ST_HOLD;
               end
            end
            default: begin
               w_state_nxt = ST_COLLECT;
            end
         endcase
      end
   end

   // Handshake and status decode; flush blocks acceptance in its own cycle
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      if (rst) begin
         in_ready = 1'b0;
         busy     = 1'b0;
      end else begin
         in_ready = (r_state == ST_COLLECT) && !flush;
         busy     = (r_state == ST_SETTLE) || (r_state == ST_HOLD);
      end
   end

   // Operand capture, settle timing, result register and completion counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx       <= IDX_FIRST;
         r_settle    <= {SETTLE_W{1'b0}};
         r_op[0]     <= {W_IN{1'b0}};
         r_op[1]     <= {W_IN{1'b0}};
         r_op[2]     <= {W_IN{1'b0}};
         r_res_valid <= 1'b0;
         r_res_data  <= {W_OUT{1'b0}};
         r_done_cnt  <= {CNT_W{1'b0}};
      end else if (flush) begin
         r_idx       <= IDX_FIRST;
         r_res_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_COLLECT: begin
               if (w_accept) begin
                  case (r_idx)
                     IDX_FIRST: begin
                        r_op[0] <= in_data;
                        r_idx   <= IDX_MID;
                     end
                     IDX_MID: begin
                        r_op[1] <= in_data;
                        r_idx   <= IDX_LAST;
                     end
                     IDX_LAST: begin
                        r_op[2]  <= in_data;
                        r_idx    <= IDX_FIRST;
                        r_settle <= SETTLE_LOAD;
                     end
                     default: begin
                        r_idx <= IDX_FIRST;
                     end
                  endcase
               end
            end
            ST_SETTLE: begin
               if (r_settle == {SETTLE_W{1'b0}}) begin
                  r_res_data  <= w_dp_res;
                  r_res_valid <= 1'b1;
               end else begin
                  r_settle <= r_settle - SETTLE_W'(1);
               end
            end
            ST_HOLD: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_done_cnt  <= r_done_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_idx       <= IDX_FIRST;
               r_res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_third_task_ctrl.sv
// Self-checking bench for third_task_ctrl: directed table, corner sequences,
// random traffic against a transaction-level model, and SETTLE_CYC=1/15 builds.
module tb_third_task_ctrl;

   localparam int S_MAIN = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        res_valid;
   logic        res_ready;
   logic [16:0] res_data;
   logic [15:0] done_cnt;
   logic        busy;

   logic             a_valid;
   logic             a_flush;
   logic             a_rready;
   logic [7:0]       a_data0;
   logic [7:0]       a_data1;
   logic [1:0]       a_ir;
   logic [1:0]       a_rv;
   logic [1:0]       a_busy;
   logic [1:0][16:0] a_rd;
   logic [1:0][3:0]  a_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   third_task_ctrl #(.W_IN(8), .W_OUT(17), .SETTLE_CYC(S_MAIN), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .flush(flush), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .done_cnt(done_cnt), .busy(busy)
   );

   third_task_ctrl #(.W_IN(8), .W_OUT(17), .SETTLE_CYC(1), .CNT_W(4)) dut_s1 (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ir[0]), .in_data(a_data0),
      .flush(a_flush), .res_valid(a_rv[0]), .res_ready(a_rready), .res_data(a_rd[0]),
      .done_cnt(a_cnt[0]), .busy(a_busy[0])
   );

   third_task_ctrl #(.W_IN(8), .W_OUT(17), .SETTLE_CYC(15), .CNT_W(4)) dut_s15 (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ir[1]), .in_data(a_data1),
      .flush(a_flush), .res_valid(a_rv[1]), .res_ready(a_rready), .res_data(a_rd[1]),
      .done_cnt(a_cnt[1]), .busy(a_busy[1])
   );

   // Reference model state: collected bytes, settle countdown, pending result, count
   int q[$];
   bit m_settling = 1'b0;
   int m_rem      = 0;
   bit m_pend     = 1'b0;
   int m_res      = 0;
   int m_cnt      = 0;

   function automatic int golden(input int a, input int b, input int c);
      return a * b + c;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit f, input bit v, input int d, input bit rr);
      if (r) begin
         q.delete(); m_settling = 1'b0; m_pend = 1'b0; m_cnt = 0;
      end else if (f) begin
         q.delete(); m_settling = 1'b0; m_pend = 1'b0;
      end else if (!m_settling && !m_pend) begin
         if (v) begin
            q.push_back(d);
            if (q.size() == 3) begin
               m_settling = 1'b1;
               m_rem      = S_MAIN;
            end
         end
      end else if (m_settling) begin
         m_rem--;
         if (m_rem == 0) begin
            m_settling = 1'b0;
            m_pend     = 1'b1;
            m_res      = golden(q[0], q[1], q[2]);
            q.delete();
         end
      end else if (rr) begin
         m_pend = 1'b0;
         m_cnt  = (m_cnt + 1) % 65536;
      end
   endtask

   // One clock: drive inputs at negedge, optionally compare against the model, then advance it
   task automatic cycle(input bit r, input bit f, input bit v, input int d, input bit rr,
                        input bit chk);
      @(negedge clk);
      rst = r; flush = f; in_valid = v; in_data = 8'(d); res_ready = rr;
      #1;
      if (chk) begin
         check("in_ready", in_ready, (!r && !f && !m_settling && !m_pend) ? 1 : 0);
         check("busy", busy, (!r && (m_settling || m_pend)) ? 1 : 0);
         check("res_valid", res_valid, m_pend ? 1 : 0);
         check("done_cnt", done_cnt, m_cnt);
         if (m_pend) check("res_data", res_data, m_res);
      end
      model_step(r, f, v, d, rr);
   endtask

   task automatic wait_rv(input int budget, input bit rr);
      int n = 0;
      while (n < budget) begin
         cycle(1'b0, 1'b0, 1'b0, 0, rr, 1'b1);
         if (res_valid) break;
         n++;
      end
      if (n >= budget) check("wait_res_valid_timeout", 0, 1);
   endtask

   typedef struct {
      bit          r, f, v;
      logic [7:0]  d;
      bit          rr;
      bit          e_ir, e_rv, e_busy;
      logic [16:0] e_rd;
      bit          chk_rd;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl [8];

   int acc[2], acc_edge[2], res_n[2], lat_exp[2], rd_exp[2];

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0;
      a_valid = 1'b0; a_flush = 1'b0; a_rready = 1'b1; a_data0 = 8'h11; a_data1 = 8'h22;

      //            r  f  v  d      rr e_ir e_rv busy e_rd       chk cnt
      tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0,  1'b1, 16'd0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0,  1'b1, 16'd0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0,  1'b0, 16'd0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0,  1'b0, 16'd0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 17'h0,  1'b0, 16'd0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 17'h0,  1'b0, 16'd0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 17'h5,  1'b1, 16'd0};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 17'h0,  1'b0, 16'd1};

      repeat (3) cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Reset state, first handshake and back-to-back triple with SETTLE_CYC=2 latency
      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].r, tbl[i].f, tbl[i].v, int'(tbl[i].d), tbl[i].rr, 1'b0);
         check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
         check($sformatf("tbl%0d_res_valid", i), res_valid, tbl[i].e_rv);
         check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
         check($sformatf("tbl%0d_done_cnt", i), done_cnt, int'(tbl[i].e_cnt));
         if (tbl[i].chk_rd) check($sformatf("tbl%0d_res_data", i), res_data, int'(tbl[i].e_rd));
      end

      // Gapped input, consumer stalled for 5 cycles
      cycle(1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 8'h06, 1'b0, 1'b1);
      wait_rv(20, 1'b0);
      repeat (5) cycle(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
      check("stall_res_data", res_data, golden(4, 5, 6));
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      check("stall_done_cnt", done_cnt, 2);

      // Partial triple dropped by flush; the byte offered during flush is refused
      cycle(1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      check("flush_blocks_in_ready", in_ready, 0);
      cycle(1'b0, 1'b0, 1'b1, 8'h09, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 8'h0B, 1'b0, 1'b1);
      wait_rv(20, 1'b0);
      check("flush_res_data", res_data, golden(9, 10, 11));
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);

      // Flush together with res_ready in HOLD: no handoff counted
      cycle(1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 1'b1);
      wait_rv(20, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      check("flush_hold_res_valid", res_valid, 0);
      check("flush_hold_done_cnt", done_cnt, 3);

      // Random traffic against the model
      for (int i = 0; i < 500; i++) begin
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
               ($urandom_range(0, 1) == 1), 1'b1);
      end
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);

      // SETTLE_CYC=1 and 15 builds with a 4-bit counter: latency and wrap
      lat_exp[0] = 1;  rd_exp[0] = golden(8'h11, 8'h11, 8'h11);
      lat_exp[1] = 15; rd_exp[1] = golden(8'h22, 8'h22, 8'h22);
      for (int k = 0; k < 2; k++) begin
         acc[k] = 0; acc_edge[k] = 0; res_n[k] = 0;
      end
      @(negedge clk);
      a_valid = 1'b1;
      #1;
      for (int i = 0; i < 700 && res_n[1] < 17; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (a_rv[k]) begin
               check($sformatf("s%0d_latency", lat_exp[k]), i - acc_edge[k], lat_exp[k]);
               check($sformatf("s%0d_res_data", lat_exp[k]), a_rd[k], rd_exp[k]);
               check($sformatf("s%0d_busy", lat_exp[k]), a_busy[k], 1);
               check($sformatf("s%0d_done_cnt", lat_exp[k]), a_cnt[k], res_n[k] % 16);
               if (res_n[k] == 16) check($sformatf("s%0d_wrap", lat_exp[k]), a_cnt[k], 0);
               res_n[k]++;
            end
            if (a_ir[k]) begin
               acc[k]++;
               if (acc[k] == 3) begin
                  acc[k]      = 0;
                  acc_edge[k] = i + 1;
               end
            end
         end
         @(negedge clk);
         #1;
      end
      check("s1_results_seen", (res_n[0] >= 17) ? 1 : 0, 1);
      check("s15_results_seen", (res_n[1] >= 17) ? 1 : 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
